// File: rtl/bemicro_cv_pio_pkg.sv
// Shared constants for the BeMicro CV input PIO: register map, edge encodings, counter sizing.
// Latency: none (constants only). Backpressure: none.
package bemicro_cv_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE    = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // A one-cycle filter still needs a 1-bit counter so the compare stays legal.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/bemicro_cv_pio_debounce.sv
// One input bit: 2-FF synchronizer, then (with BEMICRO_CV_PIO_DEBOUNCE_EN) a stable-count filter.
// Latency: 2 clocks sync + DEBOUNCE_CYCLES filter (filter absent without the macro). Backpressure: none.
module bemicro_cv_pio_debounce
  import bemicro_cv_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_BIT        = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic stable_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {2{IDLE_BIT}};
    else          sync_q <= {sync_q[0], in_i};
  end

`ifdef BEMICRO_CV_PIO_DEBOUNCE_EN
  localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  // Any return to the accepted level restarts the count from zero.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync_q[1];
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= IDLE_BIT;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign stable_o = sync_q[1];
`endif

endmodule

// File: rtl/bemicro_cv_pio_in_irq.sv
// Avalon-MM input PIO with per-bit sync/debounce, edge capture, IRQ mask (BEMICRO_CV_PIO_DEBOUNCE_EN enables debounce).
// Latency: readdata 1 clock after address; no wait states. Backpressure: none, always accepts.
module bemicro_cv_pio_in_irq
  import bemicro_cv_pio_pkg::*;
#(
  parameter int               WIDTH           = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IDLE_VALUE      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    bemicro_cv_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_BIT        (IDLE_VALUE[i])
    ) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_i     (in_port[i]),
      .stable_o (stable[i])
    );
  end

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_det = ~prev_q & stable;
      EDGE_FALL: edge_det = prev_q & ~stable;
      default:   edge_det = prev_q ^ stable;
    endcase
  end

  // A fresh edge wins over a same-cycle write-1-to-clear.
  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr_en && address == PIO_ADDR_IRQMASK) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == PIO_ADDR_EDGE)    edge_d = edge_q & ~writedata[WIDTH-1:0];
    edge_d = edge_d | edge_det;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      PIO_ADDR_DATA:    readdata_d = 32'(stable);
      PIO_ADDR_DIR:     readdata_d = '0;
      PIO_ADDR_IRQMASK: readdata_d = 32'(mask_q);
      default:          readdata_d = 32'(edge_q);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= IDLE_VALUE;
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
    end else begin
      prev_q     <= stable;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_bemicro_cv_pio_in_irq.sv
// Directed bench for bemicro_cv_pio_in_irq: WIDTH=2, DEBOUNCE_CYCLES=4, falling-edge capture, idle-high inputs.
module tb_bemicro_cv_pio_in_irq;

  localparam int DEB = 4;
`ifdef BEMICRO_CV_PIO_DEBOUNCE_EN
  localparam int          LAT         = 2 + DEB + 1;
  localparam logic [31:0] BOUNCE_EDGE = 32'h0;
`else
  localparam int          LAT         = 3;
  localparam logic [31:0] BOUNCE_EDGE = 32'h2;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  in_port;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bemicro_cv_pio_in_irq #(
    .WIDTH           (2),
    .DEBOUNCE_CYCLES (DEB),
    .EDGE_TYPE       (1),
    .IDLE_VALUE      (2'b11)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick(1);
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    in_port = 2'b11; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    reset_n = 1'b0;
    tick(3);
    n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got %h want %h", readdata, 32'h0); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    reset_n = 1'b1;
    tick(1);
    n_checks++; if (readdata !== 32'h3) begin n_fail++; $display("FAIL reset_data got %h want %h", readdata, 32'h3); end
    bus_read(2'd1, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_dir got %h want %h", d, 32'h0); end
    bus_read(2'd2, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mask got %h want %h", d, 32'h0); end
    bus_read(2'd3, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_edge got %h want %h", d, 32'h0); end
  endtask

  task automatic test_debounce_latency();
    logic [31:0] d;
    address = 2'd0;
    in_port[0] = 1'b0;
    tick(LAT - 1);
    n_checks++; if (readdata !== 32'h3) begin n_fail++; $display("FAIL lat_early got %h want %h", readdata, 32'h3); end
    tick(1);
    n_checks++; if (readdata !== 32'h2) begin n_fail++; $display("FAIL lat_exact got %h want %h", readdata, 32'h2); end
    bus_read(2'd3, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL lat_edge got %h want %h", d, 32'h1); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL lat_irq_masked got %b want 0", irq); end
    in_port[0] = 1'b1;
    tick(LAT + 2);
    bus_read(2'd0, d);
    n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL lat_release got %h want %h", d, 32'h3); end
    bus_read(2'd3, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL lat_rise_ignored got %h want %h", d, 32'h1); end
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL lat_w1c got %h want %h", d, 32'h0); end
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    address = 2'd0;
    for (int c = 0; c < 24; c++) begin
      in_port[1] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
`ifdef BEMICRO_CV_PIO_DEBOUNCE_EN
      n_checks++; if (readdata !== 32'h3) begin n_fail++; $display("FAIL bounce_data cycle %0d got %h want %h", c, readdata, 32'h3); end
`endif
    end
    in_port[1] = 1'b1;
    tick(LAT + 2);
    n_checks++; if (readdata !== 32'h3) begin n_fail++; $display("FAIL bounce_settle got %h want %h", readdata, 32'h3); end
    bus_read(2'd3, d);
    n_checks++; if (d !== BOUNCE_EDGE) begin n_fail++; $display("FAIL bounce_edge got %h want %h", d, BOUNCE_EDGE); end
    bus_write(2'd3, 32'h3);
  endtask

  task automatic test_irq_mask();
    logic [31:0] d;
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL irq_mask_rd got %h want %h", d, 32'h1); end
    address = 2'd0;
    in_port[0] = 1'b0;
    tick(LAT - 1);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b want 0", irq); end
    tick(1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b want 1", irq); end
    bus_read(2'd3, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL irq_edge got %h want %h", d, 32'h1); end
    bus_write(2'd3, 32'h1);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want 0", irq); end
    bus_read(2'd3, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL irq_edge_clr got %h want %h", d, 32'h0); end
    bus_write(2'd0, 32'h3);
    bus_read(2'd0, d);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL irq_data_ro got %h want %h", d, 32'h2); end
    in_port[0] = 1'b1;
    tick(LAT + 2);
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d;
    in_port[0] = 1'b0;
    tick(LAT - 1);
    address = 2'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL coll_irq got %b want 1", irq); end
    bus_read(2'd3, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL coll_edge got %h want %h", d, 32'h1); end
    bus_write(2'd3, 32'h1);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL coll_clear got %b want 0", irq); end
    in_port[0] = 1'b1;
    tick(LAT + 2);
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    address = 2'd0;
    in_port[0] = 1'b0;
    tick(4);
    reset_n = 1'b0;
    #1;
    n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL abort_rst_rd got %h want %h", readdata, 32'h0); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL abort_rst_irq got %b want 0", irq); end
    tick(2);
    reset_n = 1'b1;
    address = 2'd3;
    tick(1);
    n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL abort_edge got %h want %h", readdata, 32'h0); end
    address = 2'd0;
    tick(LAT - 2);
    n_checks++; if (readdata !== 32'h3) begin n_fail++; $display("FAIL abort_idle got %h want %h", readdata, 32'h3); end
    tick(1);
    n_checks++; if (readdata !== 32'h2) begin n_fail++; $display("FAIL abort_new got %h want %h", readdata, 32'h2); end
    bus_read(2'd2, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL abort_mask got %h want %h", d, 32'h0); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL abort_irq got %b want 0", irq); end
    in_port[0] = 1'b1;
    tick(LAT + 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_debounce_latency();
    test_bounce();
    test_irq_mask();
    test_w1c_collision();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
